// File: rtl/popcount_defs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : popcount_defs                                      |
// | Description : Shared widths, limits and state codes for popcount |
// |               consumers, plus the per-word clamp helper.         |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package popcount_defs;

    localparam int WORD_W = 32;
    localparam int POP_W  = 6;
    localparam logic [POP_W-1:0] POP_MAX = 6'd32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A 32-bit word can never hold more than 32 ones; larger codes saturate.
    function automatic logic [POP_W-1:0] clamp_ones(input logic [POP_W-1:0] v);
        return (v > POP_MAX) ? POP_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_frame_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : popcount_frame_accumulator                         |
// | Description : Accumulates per-word ones counts into frames and   |
// |               emits sum / word count / max per frame.            |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module popcount_frame_accumulator
    import popcount_defs::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = $clog2(FRAME_LEN*32+1),
    parameter int CNT_W     = $clog2(FRAME_LEN+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_ones,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_words,
    output logic [POP_W-1:0] out_max,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_frame_len = CNT_W'(FRAME_LEN);

    logic [1:0]       r_state;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_words;
    logic [POP_W-1:0] r_max;
    logic [SUM_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_words;
    logic [POP_W-1:0] r_out_max;
    logic             r_err;

    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_first;
    logic             w_close;
    logic [POP_W-1:0] w_ones;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [CNT_W-1:0] w_words_nxt;
    logic [POP_W-1:0] w_max_nxt;

    always_comb begin
        w_accept    = in_valid && (r_state != ST_DONE);
        w_ones      = clamp_ones(in_ones);
        // The first beat of a frame seeds the accumulators instead of adding.
        w_first     = (r_state == ST_IDLE);
        w_sum_nxt   = (w_first ? '0 : r_sum) + SUM_W'(w_ones);
        w_words_nxt = (w_first ? '0 : r_words) + CNT_W'(1);
        w_max_nxt   = (w_first || (w_ones > r_max)) ? w_ones : r_max;
        w_close     = in_last || (w_words_nxt == c_frame_len);

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = w_close ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_words     <= '0;
            r_max       <= '0;
            r_out_sum   <= '0;
            r_out_words <= '0;
            r_out_max   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sum   <= w_sum_nxt;
                r_words <= w_words_nxt;
                r_max   <= w_max_nxt;
                if (in_ones > POP_MAX) begin
                    r_err <= 1'b1;
                end
                // Result registers only change on a closing beat, so they hold through backpressure.
                if (w_close) begin
                    r_out_sum   <= w_sum_nxt;
                    r_out_words <= w_words_nxt;
                    r_out_max   <= w_max_nxt;
                end
            end
        end
    end

    assign in_ready  = (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_out_sum;
    assign out_words = r_out_words;
    assign out_max   = r_out_max;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/popcount_frame_accumulator.md
Name: popcount_frame_accumulator

Overview:
Downstream consumer of the 32-bit combinational popcount stage. Takes a stream of 6-bit per-word ones counts over a valid/ready handshake and accumulates them into frames. A frame closes after FRAME_LEN words or on an early in_last. Emits per frame the total ones, the word count and the maximum per-word count, held until the sink accepts it.

Parameters:
FRAME_LEN, 16, words per full frame (1..1024)
SUM_W, $clog2(FRAME_LEN*32+1), width of out_sum (10 at default)
CNT_W, $clog2(FRAME_LEN+1), width of out_words (5 at default)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_ones/in_last valid
in_ready  output  1  block can accept a beat
in_ones  input  6  ones count of one 32-bit word (legal 0..32)
in_last  input  1  beat closes the frame early
out_valid  output  1  frame result valid
out_ready  input  1  sink accepts result
out_sum  output  SUM_W  total ones in frame
out_words  output  CNT_W  words in frame (1..FRAME_LEN)
out_max  output  6  largest per-word count in frame
err  output  1  sticky: illegal in_ones (>32) was accepted

Behaviour:
- Reset: synchronous, active-low; takes priority over all other inputs. Sets state IDLE, in_ready=1, out_valid=0, out_sum=0, out_words=0, out_max=0, err=0, and clears all accumulators. Reset mid-frame discards the partial frame without emitting it.
- Beat accepted iff in_valid && in_ready on a rising edge. in_ones/in_last are ignored when no beat is accepted.
- Clamp: an accepted in_ones > 32 is treated as 32 and sets err. err stays 1 until reset.
- States:
  - IDLE: no beats yet in current frame; in_ready=1.
  - ACCUM: at least 1 beat accumulated; in_ready=1.
  - DONE: result pending; in_ready=0, out_valid=1.
- Transitions:
  - IDLE->ACCUM on an accepted beat that does not close the frame.
  - IDLE->DONE on an accepted beat with in_last=1, or FRAME_LEN=1.
  - ACCUM->DONE on an accepted beat that makes the word count equal FRAME_LEN, or has in_last=1.
  - DONE->IDLE on out_valid && out_ready.
- Accumulation per accepted beat:
  - sum += clamped ones
  - words += 1
  - max = max(max, clamped ones)
  - The first beat of a frame loads sum/words/max directly; there is no stale carry-over.
- Latency: out_valid rises on the cycle after the closing beat is accepted. out_sum/out_words/out_max are registered and reflect the closing beat included.
- Output hold: out_* stay stable while out_valid && !out_ready.
- Release: on the accept cycle, out_valid=0 and in_ready=1 from the next cycle. No same-cycle bypass, so max throughput is 1 frame per FRAME_LEN+1 cycles.
- Widths: SUM_W sized for FRAME_LEN*32, so out_sum never overflows. out_words never wraps; the count is bounded by FRAME_LEN.
- in_last asserted together with the FRAME_LEN-th beat closes the frame once; no empty frame follows.
- An empty frame is impossible: a frame needs at least 1 beat.

Decomposition:
- Shared package/header popcount_defs: WORD_W=32, POP_W=6, POP_MAX=32, state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
- No sub-module required. The clamp/compare datapath and FSM fit in one module. An optional small function handles clamp-and-max.

Test Plan:
1. FRAME_LEN=4; beats 32,0,5,7 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept; sum=44, words=4, max=32; err=0.
2. Beats 3,4 with in_last on 2nd -> sum=7, words=2, max=4; next beat 9 with in_last -> sum=9, words=1, max=9 (no carry-over).
3. Frame closes, out_ready held 0 for 5 cycles while in_valid=1 -> out_valid and out_* stable, in_ready=0, no beats consumed. out_ready=1 -> out_valid drops next cycle, in_ready=1, and the pending beat is accepted the cycle after.
4. Accept in_ones=40 in frame 10,40,1,1 -> sum=44, max=32, err=1 and still 1 after subsequent frames until rst_n=0.
5. rst_n=0 for one cycle after 2 beats of 20 -> all outputs 0. A fresh frame 1,1,1,1 yields sum=4 (the partial 40 is discarded).
6. FRAME_LEN=16; 16 beats of 32 -> sum=512 (10 bits, no overflow), words=16, max=32. FRAME_LEN=1 -> every beat emits its own frame.
